// File: rtl/planificador_displays.sv
// Scan scheduler for the three floor displays: one display lit per tick,
// with per-floor blink and lamp test. All outputs come straight from flops.
module planificador_displays #(
    parameter int unsigned BLINK_HALF = 75
) (
    input  logic       clockInt_150Hz,
    input  logic       reset,
    input  logic [2:0] habilitaPisos,
    input  logic [3:0] digitoPiso1,
    input  logic [3:0] digitoPiso2,
    input  logic [3:0] digitoPiso3,
    input  logic [2:0] parpadeo,
    input  logic       prueba,
    output logic [2:0] anodos,
    output logic [6:0] segmentos,
    output logic [1:0] pisoActivo
);

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_P1   = 3'b100;
    localparam logic [2:0] S_P2   = 3'b010;
    localparam logic [2:0] S_P3   = 3'b001;

    localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ALL   = 7'h7F;

    logic [2:0]       state_q, state_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       piso_q, piso_d;
    logic [CNT_W-1:0] cntBlink_q, cntBlink_d;
    logic             faseOff_q, faseOff_d;

    logic [3:0] digito_sel;
    logic [6:0] seg_dec;
    logic       blink_sel;
    logic       wrap;

    function automatic logic [6:0] decode7(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'h7E;
            4'h1:    s = 7'h30;
            4'h2:    s = 7'h6D;
            4'h3:    s = 7'h79;
            4'h4:    s = 7'h33;
            4'h5:    s = 7'h5B;
            4'h6:    s = 7'h5F;
            4'h7:    s = 7'h70;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h7B;
            4'hA:    s = 7'h01;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Cyclic search 1->2->3->1 starting after the current slot, even if the
    // current floor itself has just been masked off.
    always_comb begin
        state_d = S_IDLE;
        if (habilitaPisos != 3'b000) begin
            case (state_q)
                S_P1: begin
                    if (habilitaPisos[1])      state_d = S_P2;
                    else if (habilitaPisos[0]) state_d = S_P3;
                    else                       state_d = S_P1;
                end
                S_P2: begin
                    if (habilitaPisos[0])      state_d = S_P3;
                    else if (habilitaPisos[2]) state_d = S_P1;
                    else                       state_d = S_P2;
                end
                S_P3: begin
                    if (habilitaPisos[2])      state_d = S_P1;
                    else if (habilitaPisos[1]) state_d = S_P2;
                    else                       state_d = S_P3;
                end
                default: begin
                    if (habilitaPisos[2])      state_d = S_P1;
                    else if (habilitaPisos[1]) state_d = S_P2;
                    else                       state_d = S_P3;
                end
            endcase
        end
    end

    always_comb begin
        digito_sel = 4'hF;
        piso_d     = 2'd0;
        case (state_d)
            S_P1: begin digito_sel = digitoPiso1; piso_d = 2'd1; end
            S_P2: begin digito_sel = digitoPiso2; piso_d = 2'd2; end
            S_P3: begin digito_sel = digitoPiso3; piso_d = 2'd3; end
            default: begin digito_sel = 4'hF; piso_d = 2'd0; end
        endcase
    end

    assign seg_dec = decode7(digito_sel);
    // One-hot state shares bit order with parpadeo, so a mask picks the bit.
    assign blink_sel = |(parpadeo & state_d);

    always_comb begin
        if (state_d == S_IDLE)          seg_d = SEG_BLANK;
        else if (prueba)                seg_d = SEG_ALL;
        else if (faseOff_q && blink_sel) seg_d = SEG_BLANK;
        else                            seg_d = seg_dec;
    end

    assign wrap       = (cntBlink_q == CNT_LAST);
    assign cntBlink_d = wrap ? '0 : cntBlink_q + 1'b1;
    assign faseOff_d  = faseOff_q ^ wrap;

    always_ff @(posedge clockInt_150Hz) begin
        if (reset) begin
            state_q    <= S_P1;
            seg_q      <= SEG_BLANK;
            piso_q     <= 2'd1;
            cntBlink_q <= '0;
            faseOff_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            piso_q     <= piso_d;
            cntBlink_q <= cntBlink_d;
            faseOff_q  <= faseOff_d;
        end
    end

    assign anodos     = state_q;
    assign segmentos  = seg_q;
    assign pisoActivo = piso_q;

endmodule
